mem_port_arbiter: RTL and testbench

Shares the processor's single-port 16-bit memory between the instruction fetch stage and the data memory stage. Data-stage accesses take fixed priority, and a starvation counter guarantees fetch forward progress. The block returns read data to the winning requester one cycle after issue and drives per-requester stall lines that the pipeline uses to freeze the losing stage. It sits between the fetch/memory stages and the shared memory macro.

---
 rtl/mem_port_arbiter.sv | 119 +++++++++++
 tb/tb_mem_port_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port memory between instruction fetch and the data stage.
// The data stage has fixed priority. A starvation counter forces a fetch win after
// MAX_WAIT consecutive lost cycles. Read data returns one cycle after issue.
//
// Ports
//   clk, reset                      clock, synchronous active-high reset
//   if_req, if_addr                 fetch read request
//   if_stall, if_valid, if_rdata    fetch stall / response
//   dm_req, dm_we, dm_addr,
//   dm_wdata                        data-stage access request
//   dm_stall, dm_valid, dm_rdata    data-stage stall / response
//   mem_en, mem_we, mem_addr,
//   mem_wdata, mem_rdata            shared memory port
//   owner                           debug: 00 none, 01 fetch, 10 data (this cycle)
module mem_port_arbiter #(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned MAX_WAIT = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_stall,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_stall,
    output logic              dm_valid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        owner
);

    localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        StIdle,
        StRspIf,
        StRspDm
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] starve_q, starve_d;
    logic             rsp_read_q, rsp_read_d;

    logic force_if;
    logic grant_if;
    logic grant_dm;

    // Grants are suppressed during reset so the memory port stays quiet.
    always_comb begin
        force_if = (starve_q == CNT_W'(MAX_WAIT));
        grant_dm = ~reset & dm_req & ~(if_req & force_if);
        grant_if = ~reset & if_req & ~grant_dm;
    end

    always_comb begin
        mem_en    = grant_if | grant_dm;
        mem_we    = grant_dm & dm_we;
        mem_wdata = dm_wdata;
        mem_addr  = '0;
        if (grant_dm) begin
            mem_addr = dm_addr;
        end else if (grant_if) begin
            mem_addr = if_addr;
        end
        owner    = {grant_dm, grant_if};
        if_stall = if_req & ~grant_if;
        dm_stall = dm_req & ~grant_dm;
    end

    // Next state follows only this cycle's grant; any state may follow any other.
    always_comb begin
        state_d    = StIdle;
        rsp_read_d = grant_dm & ~dm_we;
        if (grant_if) begin
            state_d = StRspIf;
        end else if (grant_dm) begin
            state_d = StRspDm;
        end

        starve_d = starve_q;
        if (~if_req | grant_if) begin
            starve_d = '0;
        end else if (starve_q != CNT_W'(MAX_WAIT)) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            starve_q   <= '0;
            rsp_read_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            rsp_read_q <= rsp_read_d;
        end
    end

    // Valids are masked by reset so a grant just before reset never responds.
    always_comb begin
        if_valid = ~reset & (state_q == StRspIf);
        dm_valid = ~reset & (state_q == StRspDm);
        if_rdata = if_valid ? mem_rdata : '0;
        dm_rdata = (dm_valid & rsp_read_q) ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [15:0] if_addr;
    logic        if_stall;
    logic        if_valid;
    logic [15:0] if_rdata;
    logic        dm_req;
    logic        dm_we;
    logic [15:0] dm_addr;
    logic [15:0] dm_wdata;
    logic        dm_stall;
    logic        dm_valid;
    logic [15:0] dm_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = 16'h0000;
    logic [1:0]  owner;

    int n_checks = 0;
    int n_errors = 0;

    mem_port_arbiter #(
        .ADDR_W  (16),
        .DATA_W  (16),
        .MAX_WAIT(3)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_stall (if_stall),
        .if_valid (if_valid),
        .if_rdata (if_rdata),
        .dm_req   (dm_req),
        .dm_we    (dm_we),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_stall (dm_stall),
        .dm_valid (dm_valid),
        .dm_rdata (dm_rdata),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .owner    (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port memory model: read data one cycle after a read strobe.
    logic [15:0] mem [0:255];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        for (int i = 0; i < 4; i++) mem[i] = 16'h1110 + 16'(i);
    end
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr[7:0]];
        end
    end

    typedef struct {
        logic        rst;
        logic        ireq;
        logic [15:0] iaddr;
        logic        dreq;
        logic        dwe;
        logic [15:0] daddr;
        logic [15:0] dwd;
        logic        e_istall;
        logic        e_dstall;
        logic        e_en;
        logic        e_we;
        logic [15:0] e_addr;
        logic [1:0]  e_owner;
        logic        e_ivalid;
        logic [15:0] e_irdata;
        logic        e_dvalid;
        logic [15:0] e_drdata;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int step, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s step %0d: got %h, expected %h", name, step, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic ireq, input logic [15:0] iaddr,
                         input logic dreq, input logic dwe, input logic [15:0] daddr,
                         input logic [15:0] dwd);
        reset    = rst;
        if_req   = ireq;
        if_addr  = iaddr;
        dm_req   = dreq;
        dm_we    = dwe;
        dm_addr  = daddr;
        dm_wdata = dwd;
    endtask

    initial begin
        drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);

        // rst ireq iaddr dreq dwe daddr dwd | istall dstall en we addr owner iv irdata dv drdata
        // Reset with both requesting, then first cycle grants data.
        vecs.push_back('{1, 1, 16'h0000, 1, 0, 16'h0002, 16'h0000, 1, 1, 0, 0, 16'h0000, 2'b00, 0, 16'h0000, 0, 16'h0000});
        vecs.push_back('{1, 1, 16'h0000, 1, 0, 16'h0002, 16'h0000, 1, 1, 0, 0, 16'h0000, 2'b00, 0, 16'h0000, 0, 16'h0000});
        vecs.push_back('{0, 1, 16'h0000, 1, 0, 16'h0002, 16'h0000, 1, 0, 1, 0, 16'h0002, 2'b10, 0, 16'h0000, 0, 16'h0000});
        vecs.push_back('{0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 2'b00, 0, 16'h0000, 1, 16'h1112});
        // Fetch only, addresses 0..3.
        vecs.push_back('{0, 1, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 1, 0, 16'h0000, 2'b01, 0, 16'h0000, 0, 16'h0000});
        vecs.push_back('{0, 1, 16'h0001, 0, 0, 16'h0000, 16'h0000, 0, 0, 1, 0, 16'h0001, 2'b01, 1, 16'h1110, 0, 16'h0000});
        vecs.push_back('{0, 1, 16'h0002, 0, 0, 16'h0000, 16'h0000, 0, 0, 1, 0, 16'h0002, 2'b01, 1, 16'h1111, 0, 16'h0000});
        vecs.push_back('{0, 1, 16'h0003, 0, 0, 16'h0000, 16'h0000, 0, 0, 1, 0, 16'h0003, 2'b01, 1, 16'h1112, 0, 16'h0000});
        vecs.push_back('{0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 2'b00, 1, 16'h1113, 0, 16'h0000});
        // Write 0xBEEF to 0x40, read it back.
        vecs.push_back('{0, 0, 16'h0000, 1, 1, 16'h0040, 16'hBEEF, 0, 0, 1, 1, 16'h0040, 2'b10, 0, 16'h0000, 0, 16'h0000});
        vecs.push_back('{0, 0, 16'h0000, 1, 0, 16'h0040, 16'hBEEF, 0, 0, 1, 0, 16'h0040, 2'b10, 0, 16'h0000, 1, 16'h0000});
        vecs.push_back('{0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 2'b00, 0, 16'h0000, 1, 16'hBEEF});
        // Continuous contention: D,D,D,F,D,D,D,F.
        vecs.push_back('{0, 1, 16'h0001, 1, 0, 16'h0003, 16'h0000, 1, 0, 1, 0, 16'h0003, 2'b10, 0, 16'h0000, 0, 16'h0000});
        vecs.push_back('{0, 1, 16'h0001, 1, 0, 16'h0003, 16'h0000, 1, 0, 1, 0, 16'h0003, 2'b10, 0, 16'h0000, 1, 16'h1113});
        vecs.push_back('{0, 1, 16'h0001, 1, 0, 16'h0003, 16'h0000, 1, 0, 1, 0, 16'h0003, 2'b10, 0, 16'h0000, 1, 16'h1113});
        vecs.push_back('{0, 1, 16'h0001, 1, 0, 16'h0003, 16'h0000, 0, 1, 1, 0, 16'h0001, 2'b01, 0, 16'h0000, 1, 16'h1113});
        vecs.push_back('{0, 1, 16'h0001, 1, 0, 16'h0003, 16'h0000, 1, 0, 1, 0, 16'h0003, 2'b10, 1, 16'h1111, 0, 16'h0000});
        vecs.push_back('{0, 1, 16'h0001, 1, 0, 16'h0003, 16'h0000, 1, 0, 1, 0, 16'h0003, 2'b10, 0, 16'h0000, 1, 16'h1113});
        vecs.push_back('{0, 1, 16'h0001, 1, 0, 16'h0003, 16'h0000, 1, 0, 1, 0, 16'h0003, 2'b10, 0, 16'h0000, 1, 16'h1113});
        vecs.push_back('{0, 1, 16'h0001, 1, 0, 16'h0003, 16'h0000, 0, 1, 1, 0, 16'h0001, 2'b01, 0, 16'h0000, 1, 16'h1113});
        // Fetch loses 2, withdraws, re-requests: loses 3 more before its forced win.
        vecs.push_back('{0, 1, 16'h0001, 1, 0, 16'h0003, 16'h0000, 1, 0, 1, 0, 16'h0003, 2'b10, 1, 16'h1111, 0, 16'h0000});
        vecs.push_back('{0, 1, 16'h0001, 1, 0, 16'h0003, 16'h0000, 1, 0, 1, 0, 16'h0003, 2'b10, 0, 16'h0000, 1, 16'h1113});
        vecs.push_back('{0, 0, 16'h0000, 1, 0, 16'h0003, 16'h0000, 0, 0, 1, 0, 16'h0003, 2'b10, 0, 16'h0000, 1, 16'h1113});
        vecs.push_back('{0, 1, 16'h0001, 1, 0, 16'h0003, 16'h0000, 1, 0, 1, 0, 16'h0003, 2'b10, 0, 16'h0000, 1, 16'h1113});
        vecs.push_back('{0, 1, 16'h0001, 1, 0, 16'h0003, 16'h0000, 1, 0, 1, 0, 16'h0003, 2'b10, 0, 16'h0000, 1, 16'h1113});
        vecs.push_back('{0, 1, 16'h0001, 1, 0, 16'h0003, 16'h0000, 1, 0, 1, 0, 16'h0003, 2'b10, 0, 16'h0000, 1, 16'h1113});
        vecs.push_back('{0, 1, 16'h0001, 1, 0, 16'h0003, 16'h0000, 0, 1, 1, 0, 16'h0001, 2'b01, 0, 16'h0000, 1, 16'h1113});
        vecs.push_back('{0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 2'b00, 1, 16'h1111, 0, 16'h0000});

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            drive(vecs[i].rst, vecs[i].ireq, vecs[i].iaddr, vecs[i].dreq, vecs[i].dwe,
                  vecs[i].daddr, vecs[i].dwd);
            @(negedge clk);
            chk("if_stall",  i, 32'(if_stall),  32'(vecs[i].e_istall));
            chk("dm_stall",  i, 32'(dm_stall),  32'(vecs[i].e_dstall));
            chk("mem_en",    i, 32'(mem_en),    32'(vecs[i].e_en));
            chk("mem_we",    i, 32'(mem_we),    32'(vecs[i].e_we));
            chk("mem_addr",  i, 32'(mem_addr),  32'(vecs[i].e_addr));
            chk("mem_wdata", i, 32'(mem_wdata), 32'(vecs[i].dwd));
            chk("owner",     i, 32'(owner),     32'(vecs[i].e_owner));
            chk("if_valid",  i, 32'(if_valid),  32'(vecs[i].e_ivalid));
            chk("if_rdata",  i, 32'(if_rdata),  32'(vecs[i].e_irdata));
            chk("dm_valid",  i, 32'(dm_valid),  32'(vecs[i].e_dvalid));
            chk("dm_rdata",  i, 32'(dm_rdata),  32'(vecs[i].e_drdata));
        end

        // Data read granted, reset pulsed the next cycle: its response must vanish.
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0002, 16'h0000);
        @(negedge clk);
        chk("rstpulse owner", 100, 32'(owner), 32'd2);
        chk("rstpulse mem_en", 100, 32'(mem_en), 32'd1);

        @(posedge clk); #1;
        drive(1'b1, 1'b1, 16'h0001, 1'b1, 1'b0, 16'h0002, 16'h0000);
        @(negedge clk);
        chk("rstpulse dm_valid", 101, 32'(dm_valid), 32'd0);
        chk("rstpulse dm_rdata", 101, 32'(dm_rdata), 32'd0);
        chk("rstpulse if_valid", 101, 32'(if_valid), 32'd0);
        chk("rstpulse mem_en", 101, 32'(mem_en), 32'd0);
        chk("rstpulse if_stall", 101, 32'(if_stall), 32'd1);
        chk("rstpulse dm_stall", 101, 32'(dm_stall), 32'd1);

        @(posedge clk); #1;
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
        @(negedge clk);
        chk("postrst dm_valid", 102, 32'(dm_valid), 32'd0);
        chk("postrst if_valid", 102, 32'(if_valid), 32'd0);
        chk("postrst owner", 102, 32'(owner), 32'd0);

        @(posedge clk); #1;
        @(negedge clk);
        chk("postrst2 dm_valid", 103, 32'(dm_valid), 32'd0);
        chk("postrst2 if_valid", 103, 32'(if_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
